// File: rtl/ddr2_req_arbiter_pkg.sv
// Shared types and constants for the DDR2 request arbiter.
// Optional starvation guard is enabled with macro ARB_STARVE_GUARD_EN.
package ddr2_req_arbiter_pkg;

   localparam int ADDR_W = 31;
   localparam int DATA_W = 128;
   localparam int MASK_W = 16;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GNT_RD  = 2'b01,
      GNT_WR1 = 2'b10,
      GNT_WR2 = 2'b11
   } arb_state_e;

endpackage

// File: rtl/ddr2_req_arbiter.sv
// Arbitrates a pixel-feeder read client and a frame-fill write client onto the DDR2 FIFOs.
// Define ARB_STARVE_GUARD_EN to force a write grant after STARVE_LIMIT reads while a write waits.
module ddr2_req_arbiter
   import ddr2_req_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ff_af_wr_en,
   input  logic [ADDR_W-1:0] ff_af_addr_din,
   input  logic              ff_wdf_wr_en,
   input  logic [DATA_W-1:0] ff_wdf_din,
   input  logic [MASK_W-1:0] ff_wdf_mask_din,
   output logic              ff_af_full,
   output logic              ff_wdf_full,
   input  logic              rd_af_wr_en,
   input  logic [ADDR_W-1:0] rd_af_addr_din,
   output logic              rd_af_full,
   input  logic              af_full,
   input  logic              wdf_full,
   output logic              af_wr_en,
   output logic [ADDR_W-1:0] af_addr_din,
   output logic [2:0]        af_cmd_din,
   output logic              wdf_wr_en,
   output logic [DATA_W-1:0] wdf_din,
   output logic [MASK_W-1:0] wdf_mask_din
);

   arb_state_e state_r;
   logic       rd_take_s;
   logic       wr_joint_s;
   logic       wr_beat2_s;
   logic       force_wr_s;

   assign rd_take_s  = rd_af_wr_en & ~af_full;
   assign wr_joint_s = ff_af_wr_en & ff_wdf_wr_en & ~af_full & ~wdf_full;
   assign wr_beat2_s = ff_wdf_wr_en & ~wdf_full;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_cnt_r;

   assign force_wr_s = ff_af_wr_en & (starve_cnt_r == CNT_W'(STARVE_LIMIT));

   // Count read grants taken while a write is waiting; a write grant resets it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == IDLE) begin
         if (force_wr_s || (!rd_af_wr_en && ff_af_wr_en)) begin
            starve_cnt_r <= {CNT_W{1'b0}};
         end else if (rd_af_wr_en && ff_af_wr_en) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end
`else
   logic unused_limit_s;

   assign force_wr_s     = 1'b0;
   assign unused_limit_s = (STARVE_LIMIT > 0);
`endif

   // Grant state machine; a write burst holds the grant until both beats are pushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (force_wr_s) begin
                  state_r <= GNT_WR1;
               end else if (rd_af_wr_en) begin
                  state_r <= GNT_RD;
               end else if (ff_af_wr_en) begin
                  state_r <= GNT_WR1;
               end else begin
                  state_r <= IDLE;
               end
            end
            GNT_RD:  state_r <= rd_take_s  ? IDLE    : GNT_RD;
            GNT_WR1: state_r <= wr_joint_s ? GNT_WR2 : GNT_WR1;
            GNT_WR2: state_r <= wr_beat2_s ? IDLE    : GNT_WR2;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Route the granted client to the DDR2 FIFOs; ungranted clients see full.
   always_comb begin
      ff_af_full   = 1'b1;
      ff_wdf_full  = 1'b1;
      rd_af_full   = 1'b1;
      af_wr_en     = 1'b0;
      af_addr_din  = {ADDR_W{1'b0}};
      af_cmd_din   = CMD_WRITE;
      wdf_wr_en    = 1'b0;
      wdf_din      = {DATA_W{1'b0}};
      wdf_mask_din = {MASK_W{1'b1}};
      case (state_r)
         GNT_RD: begin
            af_wr_en    = rd_take_s;
            af_addr_din = rd_af_addr_din;
            af_cmd_din  = CMD_READ;
            rd_af_full  = af_full;
         end
         GNT_WR1: begin
            // Address and first beat must go together, so either FIFO full stalls both.
            ff_af_full   = af_full | wdf_full;
            ff_wdf_full  = af_full | wdf_full;
            af_wr_en     = wr_joint_s;
            wdf_wr_en    = wr_joint_s;
            af_addr_din  = ff_af_addr_din;
            wdf_din      = ff_wdf_din;
            wdf_mask_din = wr_joint_s ? ff_wdf_mask_din : {MASK_W{1'b1}};
         end
         GNT_WR2: begin
            ff_wdf_full  = wdf_full;
            wdf_wr_en    = wr_beat2_s;
            wdf_din      = ff_wdf_din;
            wdf_mask_din = wr_beat2_s ? ff_wdf_mask_din : {MASK_W{1'b1}};
         end
         IDLE: begin
            af_wr_en = 1'b0;
         end
         default: begin
            af_wr_en = 1'b0;
         end
      endcase
   end

endmodule
